vend_coin_arbiter: RTL and testbench

//  Shares one vending_mealy FSM between two coin slots (A, B). Buffers coin events per slot,

---
 rtl/vend_coin_arbiter.sv | 226 ++++++++++++++++++++++
 tb/tb_vend_coin_arbiter.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/vend_coin_arbiter.sv
// Two-slot coin arbiter in front of a shared vending_mealy FSM.
// Define VEND_ARB_STATS_EN to add vend/reject statistics counters.
module vend_coin_arbiter #(
  parameter int FIFO_DEPTH     = 4,
  parameter int GAP_CYCLES     = 1,
  parameter int HOLDOFF_CYCLES = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] coin_a,
  input  logic [1:0] coin_b,
  output logic       full_a,
  output logic       full_b,
  output logic       rej_a,
  output logic       rej_b,
  output logic [1:0] coin_out,
  input  logic       dispense,
  input  logic       chg5,
  output logic       grant_a,
  output logic       grant_b,
  output logic       vend_a,
  output logic       vend_b,
  output logic       chg_a,
  output logic       chg_b
`ifdef VEND_ARB_STATS_EN
 ,output logic [15:0] vend_cnt_a,
  output logic [15:0] vend_cnt_b,
  output logic [15:0] rej_cnt
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH = (AW+1)'(FIFO_DEPTH);
  localparam int TM0 = (TIMEOUT_CYCLES > HOLDOFF_CYCLES) ?
                       TIMEOUT_CYCLES : HOLDOFF_CYCLES;
  localparam int TMAX = (TM0 > GAP_CYCLES) ? TM0 : GAP_CYCLES;
  localparam int TW = (TMAX > 2) ? $clog2(TMAX) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_GAP   = 2'd2;
  localparam logic [1:0] S_HOLD  = 2'd3;

  logic [1:0]    coin_in [2];
  logic [1:0]    mem_q [2][FIFO_DEPTH];
  logic [AW-1:0] wp_q [2];
  logic [AW-1:0] wp_d [2];
  logic [AW-1:0] rp_q [2];
  logic [AW-1:0] rp_d [2];
  logic [AW:0]   cnt_q [2];
  logic [AW:0]   cnt_d [2];
  logic [1:0]    head [2];
  logic [1:0]    push;
  logic [1:0]    pop;
  logic [1:0]    ne;
  logic [1:0]    full_q, full_d;
  logic [1:0]    rej_q, rej_d;

  logic [1:0]    state_q, state_d;
  logic [1:0]    own_q, own_d;
  logic          last_q, last_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic [1:0]    coin_q, coin_d;
  logic [1:0]    vend_q, vend_d;
  logic [1:0]    chg_q, chg_d;
  logic [1:0]    sel;

  assign coin_in[0] = coin_a;
  assign coin_in[1] = coin_b;

  // A full FIFO rejects even when it pops in the same cycle
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      head[i]  = mem_q[i][rp_q[i]];
      ne[i]    = (cnt_q[i] != '0);
      push[i]  = (coin_in[i] == 2'b01 || coin_in[i] == 2'b10) &&
                 (cnt_q[i] != DEPTH);
      rej_d[i] = (coin_in[i] == 2'b11) ||
                 ((coin_in[i] != 2'b00) && (cnt_q[i] == DEPTH));
      wp_d[i]  = wp_q[i] + AW'(push[i]);
      rp_d[i]  = rp_q[i] + AW'(pop[i]);
      cnt_d[i] = cnt_q[i] + (AW+1)'(push[i]) - (AW+1)'(pop[i]);
      full_d[i] = (cnt_d[i] == DEPTH);
    end
  end

  always_comb begin
    state_d = state_q;
    own_d   = own_q;
    last_d  = last_q;
    tmr_d   = tmr_q;
    coin_d  = 2'b00;
    vend_d  = 2'b00;
    chg_d   = 2'b00;
    pop     = 2'b00;
    sel     = 2'b00;
    case (state_q)
      S_IDLE: begin
        if (own_q == 2'b00) begin
          unique case (1'b1)
            ne[0] && (!ne[1] || last_q):  sel = 2'b01;
            ne[1] && (!ne[0] || !last_q): sel = 2'b10;
            default:                      sel = 2'b00;
          endcase
        end else begin
          sel = own_q & ne;
        end
        if (sel != 2'b00) begin
          pop     = sel;
          coin_d  = sel[0] ? head[0] : head[1];
          own_d   = sel;
          tmr_d   = '0;
          state_d = S_ISSUE;
        end else if (own_q != 2'b00) begin
          if (tmr_q == TW'(TIMEOUT_CYCLES - 1)) begin
            own_d = 2'b00;
            tmr_d = '0;
          end else begin
            tmr_d = tmr_q + 1'b1;
          end
        end
      end
      S_ISSUE: begin
        if (dispense) begin
          vend_d  = own_q;
          chg_d   = own_q & {2{chg5}};
          last_d  = own_q[1];
          own_d   = 2'b00;
          tmr_d   = TW'(HOLDOFF_CYCLES - 1);
          state_d = S_HOLD;
        end else begin
          tmr_d   = TW'(GAP_CYCLES - 1);
          state_d = S_GAP;
        end
      end
      default: begin
        if (tmr_q == '0) begin
          state_d = S_IDLE;
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 2; i++) begin
        for (int j = 0; j < FIFO_DEPTH; j++) mem_q[i][j] <= 2'b00;
        wp_q[i]  <= '0;
        rp_q[i]  <= '0;
        cnt_q[i] <= '0;
      end
      full_q  <= 2'b00;
      rej_q   <= 2'b00;
      state_q <= S_IDLE;
      own_q   <= 2'b00;
      last_q  <= 1'b1;
      tmr_q   <= '0;
      coin_q  <= 2'b00;
      vend_q  <= 2'b00;
      chg_q   <= 2'b00;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (push[i]) mem_q[i][wp_q[i]] <= coin_in[i];
        wp_q[i]  <= wp_d[i];
        rp_q[i]  <= rp_d[i];
        cnt_q[i] <= cnt_d[i];
      end
      full_q  <= full_d;
      rej_q   <= rej_d;
      state_q <= state_d;
      own_q   <= own_d;
      last_q  <= last_d;
      tmr_q   <= tmr_d;
      coin_q  <= coin_d;
      vend_q  <= vend_d;
      chg_q   <= chg_d;
    end
  end

  assign full_a   = full_q[0];
  assign full_b   = full_q[1];
  assign rej_a    = rej_q[0];
  assign rej_b    = rej_q[1];
  assign coin_out = coin_q;
  assign grant_a  = own_q[0];
  assign grant_b  = own_q[1];
  assign vend_a   = vend_q[0];
  assign vend_b   = vend_q[1];
  assign chg_a    = chg_q[0];
  assign chg_b    = chg_q[1];

`ifdef VEND_ARB_STATS_EN
  logic [15:0] vca_q, vca_d;
  logic [15:0] vcb_q, vcb_d;
  logic [15:0] rc_q, rc_d;

  always_comb begin
    vca_d = vca_q;
    vcb_d = vcb_q;
    rc_d  = rc_q;
    if (vend_q[0] && vca_q != 16'hFFFF) vca_d = vca_q + 16'd1;
    if (vend_q[1] && vcb_q != 16'hFFFF) vcb_d = vcb_q + 16'd1;
    if ((rej_q != 2'b00) && rc_q != 16'hFFFF) rc_d = rc_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vca_q <= '0;
      vcb_q <= '0;
      rc_q  <= '0;
    end else begin
      vca_q <= vca_d;
      vcb_q <= vcb_d;
      rc_q  <= rc_d;
    end
  end

  assign vend_cnt_a = vca_q;
  assign vend_cnt_b = vcb_q;
  assign rej_cnt    = rc_q;
`endif

endmodule

// File: tb/tb_vend_coin_arbiter.sv
// Directed bench for vend_coin_arbiter with a price-20 vending_mealy model.
// Checks reset, issue/gap/hold timing, arbitration, overflow, invalid, timeout.
module tb_vend_coin_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] coin_a = 2'b00;
  logic [1:0] coin_b = 2'b00;
  logic       full_a, full_b, rej_a, rej_b;
  logic [1:0] coin_out;
  logic       dispense, chg5;
  logic       grant_a, grant_b;
  logic       vend_a, vend_b, chg_a, chg_b;

  int nvec = 0;
  int nerr = 0;
  int credit = 0;
  int cval;

  always #5 clk = ~clk;

  vend_coin_arbiter dut (
    .clk      (clk),
    .rst      (rst),
    .coin_a   (coin_a),
    .coin_b   (coin_b),
    .full_a   (full_a),
    .full_b   (full_b),
    .rej_a    (rej_a),
    .rej_b    (rej_b),
    .coin_out (coin_out),
    .dispense (dispense),
    .chg5     (chg5),
    .grant_a  (grant_a),
    .grant_b  (grant_b),
    .vend_a   (vend_a),
    .vend_b   (vend_b),
    .chg_a    (chg_a),
    .chg_b    (chg_b)
  );

  // vending_mealy stand-in: price 20, 5 change on 25
  always_comb begin
    cval = (coin_out == 2'b01) ? 5 : (coin_out == 2'b10) ? 10 : 0;
    dispense = (cval != 0) && (credit + cval >= 20);
    chg5 = dispense && (credit + cval == 25);
  end

  always @(posedge clk or negedge rst) begin
    if (!rst) credit <= 0;
    else if (cval != 0) credit <= dispense ? 0 : credit + cval;
  end

  task automatic chk(input string tag, input logic [7:0] got,
                     input logic [7:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input logic [1:0] a, input logic [1:0] b);
    coin_a = a;
    coin_b = b;
    @(posedge clk);
    #1;
    coin_a = 2'b00;
    coin_b = 2'b00;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    repeat (2) step(2'b00, 2'b00);
    rst = 1'b1;
    step(2'b00, 2'b00);
  endtask

  initial begin
    do_reset();
    chk("rst_coin", {6'd0, coin_out}, 8'h00);
    chk("rst_grant", {6'd0, grant_b, grant_a}, 8'h00);
    chk("rst_full", {6'd0, full_b, full_a}, 8'h00);
    chk("rst_pulse", {4'd0, vend_a, vend_b, rej_a, rej_b}, 8'h00);

    // T1: reset asserted while A's coin is in ISSUE and B is full
    step(2'b10, 2'b00);
    step(2'b00, 2'b01);
    step(2'b10, 2'b01);
    step(2'b00, 2'b01);
    step(2'b00, 2'b01);
    chk("t1_pre_coin", {6'd0, coin_out}, 8'h02);
    chk("t1_pre_full", {6'd0, full_b, full_a}, 8'h02);
    rst = 1'b0;
    #1;
    chk("t1_coin", {6'd0, coin_out}, 8'h00);
    chk("t1_grant", {6'd0, grant_b, grant_a}, 8'h00);
    chk("t1_full", {6'd0, full_b, full_a}, 8'h00);
    step(2'b00, 2'b00);
    rst = 1'b1;
    repeat (3) step(2'b00, 2'b00);
    chk("t1_empty_grant", {6'd0, grant_b, grant_a}, 8'h00);
    chk("t1_empty_coin", {6'd0, coin_out}, 8'h00);

    // T2: A 10,10
    step(2'b10, 2'b00);
    step(2'b10, 2'b00);
    chk("t2_c1", {6'd0, coin_out}, 8'h02);
    chk("t2_grant", {6'd0, grant_b, grant_a}, 8'h01);
    step(2'b00, 2'b00);
    chk("t2_gap", {6'd0, coin_out}, 8'h00);
    step(2'b00, 2'b00);
    chk("t2_idle", {6'd0, coin_out}, 8'h00);
    step(2'b00, 2'b00);
    chk("t2_c2", {6'd0, coin_out}, 8'h02);
    step(2'b00, 2'b00);
    chk("t2_vend", {6'd0, vend_a, chg_a}, 8'h02);
    chk("t2_drop", {6'd0, grant_b, grant_a}, 8'h00);
    step(2'b00, 2'b00);
    chk("t2_vend_pulse", {7'd0, vend_a}, 8'h00);
    repeat (3) step(2'b00, 2'b00);

    // T3: A 10,5,10 with B 10 at the first cycle
    do_reset();
    step(2'b10, 2'b10);
    step(2'b01, 2'b00);
    chk("t3_tie", {6'd0, grant_b, grant_a}, 8'h01);
    chk("t3_c1", {6'd0, coin_out}, 8'h02);
    step(2'b10, 2'b00);
    step(2'b00, 2'b00);
    step(2'b00, 2'b00);
    chk("t3_c2", {6'd0, coin_out}, 8'h01);
    repeat (3) step(2'b00, 2'b00);
    chk("t3_c3", {6'd0, coin_out}, 8'h02);
    chk("t3_b_wait", {7'd0, grant_b}, 8'h00);
    step(2'b00, 2'b00);
    chk("t3_vend", {4'd0, vend_a, chg_a, vend_b, chg_b}, 8'h0c);
    repeat (4) step(2'b00, 2'b00);
    chk("t3_hold", {5'd0, grant_b, coin_out}, 8'h00);
    step(2'b00, 2'b00);
    chk("t3_b_grant", {6'd0, grant_b, grant_a}, 8'h02);
    chk("t3_b_coin", {6'd0, coin_out}, 8'h02);

    // T4 + T6: B overflows while A owns, then A times out
    do_reset();
    step(2'b01, 2'b00);
    step(2'b00, 2'b01);
    chk("t4_a_coin", {6'd0, coin_out}, 8'h01);
    step(2'b00, 2'b01);
    step(2'b00, 2'b01);
    chk("t4_full3", {7'd0, full_b}, 8'h00);
    step(2'b00, 2'b01);
    chk("t4_full4", {7'd0, full_b}, 8'h01);
    step(2'b00, 2'b01);
    chk("t4_rej", {6'd0, rej_a, rej_b}, 8'h01);
    step(2'b00, 2'b00);
    chk("t4_rej_pulse", {7'd0, rej_b}, 8'h00);
    chk("t4_held", {4'd0, grant_b, grant_a, coin_out}, 8'h04);
    repeat (60) step(2'b00, 2'b00);
    chk("t6_pre", {6'd0, grant_b, grant_a}, 8'h01);
    step(2'b00, 2'b00);
    chk("t6_release", {6'd0, grant_b, grant_a}, 8'h00);
    step(2'b00, 2'b00);
    chk("t6_b_grant", {6'd0, grant_b, grant_a}, 8'h02);
    chk("t6_b_coin", {6'd0, coin_out}, 8'h01);
    chk("t6_b_unfull", {7'd0, full_b}, 8'h00);
    repeat (6) step(2'b00, 2'b00);
    chk("t6_b_c3", {6'd0, coin_out}, 8'h01);
    step(2'b00, 2'b00);
    chk("t6_b_vend", {4'd0, vend_a, chg_a, vend_b, chg_b}, 8'h02);

    // T5: invalid codes
    do_reset();
    step(2'b11, 2'b11);
    chk("t5_rej", {6'd0, rej_a, rej_b}, 8'h03);
    step(2'b00, 2'b00);
    chk("t5_rej_pulse", {6'd0, rej_a, rej_b}, 8'h00);
    chk("t5_quiet", {4'd0, grant_b, grant_a, coin_out}, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
